wr_ddr_op: RTL and testbench

//  Write-side counterpart of the DDR read path: buffers result words (FC/conv outputs) from the compute array
//  and writes them to DDR through the MIG-style app interface (cmd port + write-data FIFO port).

---
 rtl/wr_ddr_op_pkg.sv | 18 +
 rtl/wr_ddr_op_if.sv | 25 ++
 rtl/wr_ddr_fifo.sv | 61 ++++++
 rtl/wr_ddr_op.sv | 145 ++++++++++++++
 tb/tb_wr_ddr_op.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wr_ddr_op_pkg.sv
// Shared constants and types for the DDR write-out path.
package wr_ddr_op_pkg;

    localparam logic [2:0]  WR_CMD    = 3'b000;
    localparam int unsigned ADDR_STEP = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_e;

    // Width needed to hold a lane count in the range 1..lanes.
    function automatic int unsigned lane_cnt_w(input int unsigned lanes);
        return $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/wr_ddr_op_if.sv
// MIG-style app write interface: command port plus write-data FIFO port.
interface wr_ddr_op_if #(
    parameter int unsigned DW = 512,
    parameter int unsigned AW = 30
);
    logic            rdy;
    logic            wdf_rdy;
    logic [AW-1:0]   wr_addr;
    logic [2:0]      wr_cmd;
    logic            wr_en;
    logic [DW-1:0]   wdf_data;
    logic [DW/8-1:0] wdf_mask;
    logic            wdf_wren;
    logic            wdf_end;

    modport master (
        input  rdy, wdf_rdy,
        output wr_addr, wr_cmd, wr_en, wdf_data, wdf_mask, wdf_wren, wdf_end
    );

    modport slave (
        output rdy, wdf_rdy,
        input  wr_addr, wr_cmd, wr_en, wdf_data, wdf_mask, wdf_wren, wdf_end
    );
endinterface

// File: rtl/wr_ddr_fifo.sv
// Synchronous first-word-fall-through FIFO with hard-full, registered almost-full and count.
module wr_ddr_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             afull_o,
    output logic [AddrW:0]   count_o
);
    localparam int unsigned Depth = 1 << AddrW;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q, count_d;
    logic             afull_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AddrW+1)'(Depth));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AddrW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AddrW'(1);
            if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
            count_q <= count_d;
            afull_q <= (count_d >= (AddrW+1)'(Depth - 2));
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign afull_o = afull_q;
    assign count_o = count_q;

endmodule

// File: rtl/wr_ddr_op.sv
// Buffers compute-array result words and writes them to DDR as one burst run per job.
// Define WR_DDR_OP_MASK_EN to byte-mask lanes at or above each word's num_valid.
module wr_ddr_op
    import wr_ddr_op_pkg::*;
#(
    parameter int unsigned  FW       = 16,
    parameter int unsigned  DW       = 512,
    parameter int unsigned  AW       = 30,
    parameter int unsigned  FIFO_AW  = 4,
    parameter int unsigned  LEAD_MAX = 4,
    localparam int unsigned LANES    = DW / FW,
    localparam int unsigned NVW      = lane_cnt_w(DW / FW)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           wr_ddr_en_i,
    input  logic [AW-1:0]  wr_ddr_addr_i,
    input  logic           wr_ddr_valid_i,
    input  logic [DW-1:0]  wr_ddr_data_i,
    input  logic [NVW-1:0] wr_ddr_num_valid_i,
    input  logic           wr_ddr_last_i,
    output logic           wr_ddr_full_o,
    output logic           wr_ddr_busy_o,
    output logic           wr_ddr_done_o,
    wr_ddr_op_if.master    ddr
);
`ifdef WR_DDR_OP_MASK_EN
    localparam int unsigned EW = DW + NVW + 1;
`else
    localparam int unsigned EW = DW + 1;
`endif

    state_e         state_q, state_d;
    logic [15:0]    dcnt_q, dcnt_d, ccnt_q, ccnt_d;
    logic [AW-1:0]  base_q, base_d;
    logic           last_seen_q, last_seen_d;
    logic [EW-1:0]  fifo_wdata, fifo_head;
    logic           fifo_empty, fifo_full, fifo_afull;
    logic [FIFO_AW:0] unused_fifo_cnt;
    logic           head_last, wdf_go, wdf_pop, cmd_go, cmd_acc;

`ifdef WR_DDR_OP_MASK_EN
    logic [NVW-1:0] head_nv;
    assign fifo_wdata = {wr_ddr_last_i, wr_ddr_num_valid_i, wr_ddr_data_i};
    assign head_nv    = fifo_head[DW +: NVW];
`else
    logic unused_num_valid;
    assign unused_num_valid = ^wr_ddr_num_valid_i;
    assign fifo_wdata       = {wr_ddr_last_i, wr_ddr_data_i};
`endif
    assign head_last = fifo_head[EW-1];

    wr_ddr_fifo #(
        .Width (EW),
        .AddrW (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_ddr_valid_i),
        .data_i  (fifo_wdata),
        .pop_i   (wdf_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .afull_o (fifo_afull),
        .count_o (unused_fifo_cnt)
    );

    // Data may run at most LEAD_MAX words ahead of accepted commands; a command needs its word first.
    always_comb begin
        wdf_go  = (state_q == StWrite) && !fifo_empty && !last_seen_q &&
                  ((dcnt_q - ccnt_q) < 16'(LEAD_MAX));
        wdf_pop = wdf_go && ddr.wdf_rdy;
        cmd_go  = (state_q == StWrite) && (ccnt_q < dcnt_q);
        cmd_acc = cmd_go && ddr.rdy;
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        ccnt_d      = ccnt_q;
        base_d      = base_q;
        last_seen_d = last_seen_q;
        unique case (state_q)
            StIdle: begin
                if (wr_ddr_en_i) begin
                    state_d     = StWrite;
                    dcnt_d      = '0;
                    ccnt_d      = '0;
                    base_d      = wr_ddr_addr_i;
                    last_seen_d = 1'b0;
                end
            end
            StWrite: begin
                if (wdf_pop) begin
                    dcnt_d = dcnt_q + 16'd1;
                    if (head_last) last_seen_d = 1'b1;
                end
                if (cmd_acc) ccnt_d = ccnt_q + 16'd1;
                if (last_seen_q && (ccnt_q == dcnt_q)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            dcnt_q      <= '0;
            ccnt_q      <= '0;
            base_q      <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            ccnt_q      <= ccnt_d;
            base_q      <= base_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign wr_ddr_busy_o = (state_q != StIdle);
    assign wr_ddr_done_o = (state_q == StDone);
    assign wr_ddr_full_o = fifo_afull;

    assign ddr.wr_en    = cmd_go;
    assign ddr.wr_cmd   = WR_CMD;
    assign ddr.wr_addr  = cmd_go ? (base_q + AW'(ccnt_q) * AW'(ADDR_STEP)) : '0;
    assign ddr.wdf_wren = wdf_go;
    assign ddr.wdf_end  = wdf_go;
    assign ddr.wdf_data = wdf_go ? fifo_head[DW-1:0] : '0;

`ifdef WR_DDR_OP_MASK_EN
    always_comb begin
        ddr.wdf_mask = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (wdf_go && (l >= 32'(head_nv))) ddr.wdf_mask[l*(FW/8) +: FW/8] = '1;
        end
    end
`else
    assign ddr.wdf_mask = '0;
`endif

endmodule

// File: tb/tb_wr_ddr_op.sv
// Scoreboard bench for wr_ddr_op: directed and random jobs, cmd/data stalls, reset abort, wrap.
`timescale 1ns/1ps
module tb_wr_ddr_op;
    localparam int unsigned FW    = 16;
    localparam int unsigned DW    = 512;
    localparam int unsigned AW    = 30;
    localparam int unsigned LANES = DW / FW;
    localparam int unsigned NVW   = $clog2(LANES) + 1;
    localparam int unsigned MB    = DW / 8;
    localparam int          DEPTH = 16;
`ifdef WR_DDR_OP_MASK_EN
    localparam bit MaskEn = 1'b1;
`else
    localparam bit MaskEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic           valid = 1'b0;
    logic [DW-1:0]  data = '0;
    logic [NVW-1:0] nv = '0;
    logic           last = 1'b0;
    logic           full, busy, done;

    wr_ddr_op_if #(.DW(DW), .AW(AW)) ddr_if ();

    wr_ddr_op #(
        .FW       (FW),
        .DW       (DW),
        .AW       (AW),
        .FIFO_AW  (4),
        .LEAD_MAX (4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .wr_ddr_en_i        (en),
        .wr_ddr_addr_i      (addr),
        .wr_ddr_valid_i     (valid),
        .wr_ddr_data_i      (data),
        .wr_ddr_num_valid_i (nv),
        .wr_ddr_last_i      (last),
        .wr_ddr_full_o      (full),
        .wr_ddr_busy_o      (busy),
        .wr_ddr_done_o      (done),
        .ddr                (ddr_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] exp_data_q[$];
    logic [MB-1:0] exp_mask_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int checks = 0, errors = 0;
    int occ = 0, mon_d = 0, mon_c = 0, done_seen = 0;
    bit saw_full = 1'b0;
    int cyc = 0;
    int rdy_from = 0, rdy_to = 0, wdf_from = 0, wdf_to = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lanes at or above n keep their bytes untouched in DDR.
    function automatic logic [MB-1:0] exp_mask(input int n);
        logic [MB-1:0] m;
        m = '0;
        for (int b = 0; b < MB; b++) begin
            if (MaskEn && (b / (FW / 8) >= n)) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // DDR-side ready driver: optional random throttling plus directed low windows.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ddr_if.rdy     = !(cyc >= rdy_from && cyc < rdy_to) &&
                             (!rand_rdy || ($urandom % 4 != 0));
            ddr_if.wdf_rdy = !(cyc >= wdf_from && cyc < wdf_to) &&
                             (!rand_rdy || ($urandom % 4 != 0));
        end
    end

    // Monitor: compares DUT beats against the scoreboard heads, then applies this cycle's events.
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
            chk("reset_outputs_zero",
                |{full, busy, done, ddr_if.wr_en, ddr_if.wr_addr, ddr_if.wr_cmd,
                  ddr_if.wdf_wren, ddr_if.wdf_end, ddr_if.wdf_mask, ddr_if.wdf_data}, 1'b0);
        end else begin
            chk("full_flag", full, occ >= DEPTH - 2);
            if (full) saw_full = 1'b1;
            if (valid) chk("no_drop", occ < DEPTH, 1'b1);
            if (ddr_if.wdf_wren) begin
                if (exp_data_q.size() == 0) begin
                    chk("wdf_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("wdf_data", ddr_if.wdf_data, exp_data_q[0]);
                    chk("wdf_mask", ddr_if.wdf_mask, exp_mask_q[0]);
                end
                chk("wdf_end", ddr_if.wdf_end, 1'b1);
                chk("wdf_lead", (mon_d - mon_c) < 4, 1'b1);
            end
            if (ddr_if.wr_en) begin
                if (exp_addr_q.size() == 0) chk("cmd_unexpected", 1'b1, 1'b0);
                else chk("cmd_addr", ddr_if.wr_addr, exp_addr_q[0]);
                chk("cmd_code", ddr_if.wr_cmd, 3'b000);
                chk("cmd_after_data", mon_c < mon_d, 1'b1);
            end
            if (done) done_seen++;
            if (ddr_if.wdf_wren && ddr_if.wdf_rdy) begin
                if (exp_data_q.size() != 0) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_mask_q.pop_front());
                end
                mon_d++;
                occ--;
            end
            if (ddr_if.wr_en && ddr_if.rdy) begin
                if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                mon_c++;
            end
            if (valid) occ++;
            if (en && !busy) begin
                mon_d = 0;
                mon_c = 0;
            end
        end
    end

    task automatic run_job(input logic [AW-1:0] base, input int n, input int lastnv,
                           input bit spur, input int abort_at);
        int sent;
        int waited;
        int d0;
        sent = 0;
        d0 = done_seen;
        @(posedge clk);
        #1;
        en = 1'b1;
        addr = base;
        for (int i = 0; i < n; i++) exp_addr_q.push_back(base + AW'(i) * AW'(8));
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("busy_start", busy, 1'b1);
        while (sent < n) begin
            if (abort_at != 0 && sent == abort_at) break;
            if (spur && sent == 1) begin
                en = 1'b1;
                addr = 30'h155;
            end else begin
                en = 1'b0;
            end
            if (!full) begin
                valid = 1'b1;
                data  = rand_word();
                last  = (sent == n - 1);
                nv    = (sent == n - 1) ? NVW'(lastnv) : NVW'($urandom_range(LANES, 1));
                exp_data_q.push_back(data);
                exp_mask_q.push_back(exp_mask(int'(nv)));
                sent++;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        en = 1'b0;
        last = 1'b0;
        if (abort_at != 0) begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
            exp_data_q.delete();
            exp_mask_q.delete();
            exp_addr_q.delete();
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (2) @(negedge clk);
            chk("abort_no_done", done_seen - d0, 0);
            chk("abort_idle", busy, 1'b0);
        end else begin
            waited = 0;
            while (done_seen == d0 && waited < 1000) begin
                @(negedge clk);
                waited++;
            end
            chk("done_timeout", waited < 1000, 1'b1);
            repeat (3) @(negedge clk);
            chk("done_pulses", done_seen - d0, 1);
            chk("busy_after", busy, 1'b0);
            chk("data_q_drained", exp_data_q.size(), 0);
            chk("addr_q_drained", exp_addr_q.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_wren", ddr_if.wdf_wren, 1'b0);
        chk("rst_cmd_en", ddr_if.wr_en, 1'b0);

        run_job(30'h100, 4, LANES, 1'b0, 0);

        wdf_from = cyc + 6;
        wdf_to   = wdf_from + 5;
        run_job(30'h1000, 8, LANES, 1'b0, 0);

        rdy_from = cyc + 4;
        rdy_to   = rdy_from + 10;
        run_job(30'h2000, 16, LANES, 1'b0, 0);

        wdf_from = cyc + 3;
        wdf_to   = wdf_from + 24;
        run_job(30'h3000, 24, 7, 1'b0, 0);
        chk("saw_full", saw_full, 1'b1);

        run_job(30'h4000, 3, 3, 1'b0, 0);

        run_job(30'h5000, 6, LANES, 1'b0, 2);
        run_job(30'h200, 4, LANES, 1'b0, 0);

        run_job(30'h6000, 6, LANES, 1'b1, 0);
        run_job(30'h3FFFFFF8, 2, LANES, 1'b0, 0);

        rand_rdy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            run_job(AW'($urandom), int'($urandom_range(20, 1)), int'($urandom_range(LANES, 1)),
                    1'b0, 0);
        end
        rand_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
